// File: rtl/fixed_pow2_share_ctrl.sv
// Round-robin front end that time-shares one fixed_two_int_power unit among
// NUM_REQ requesters, tagging each issue so results return to their owner.
module fixed_pow2_share_ctrl #(
    parameter int                BITS      = 8,
    parameter logic [8*16-1:0]   PRECISION = "FIXED_4_4",
    parameter int                NUM_REQ   = 4,
    parameter int                LATENCY   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*BITS-1:0]   req_a,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      unit_in_valid,
    output logic [BITS-1:0]           unit_a,
    input  logic                      unit_out_valid,
    input  logic [BITS-1:0]           unit_c,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [NUM_REQ*BITS-1:0]   resp_c,
    output logic [NUM_REQ-1:0]        resp_ovf,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic                      err
);

    function automatic int digit_of(input logic [7:0] ch);
        if (ch >= 8'd48 && ch <= 8'd57) return int'(ch) - 48;
        return 0;
    endfunction

    // Fraction width comes from the last two characters of the format name.
    function automatic int frac_of(input logic [15:0] s);
        return digit_of(s[15:8]) * 10 + digit_of(s[7:0]);
    endfunction

    localparam int FRACTION = frac_of(PRECISION[15:0]);
    localparam int IW       = BITS - FRACTION;
    localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // The integer field is read unsigned, so every negative operand overflows.
    function automatic logic ovf_of(input logic signed [BITS-1:0] a);
        logic [IW-1:0] k;
        k = a[BITS-1:FRACTION];
        return int'(k) >= (IW - 1);
    endfunction

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
        logic           ovf;
    } tag_t;

    logic [IDW-1:0]           ptr;
    logic [NUM_REQ-1:0]       busy;
    logic [NUM_REQ-1:0]       elig;
    logic [NUM_REQ-1:0]       grant;
    logic [IDW-1:0]           grant_id;
    logic                     grant_any;
    logic [IDW-1:0]           ptr_next;
    logic signed [BITS-1:0]   sel_a;
    tag_t                     tag_p0;
    tag_t                     tag_p1 [LATENCY];
    tag_t                     head;
    logic                     retire;
    int                       idx;

    always_comb begin
        elig      = req_valid & ~busy;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_any && elig[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
                grant_any  = 1'b1;
            end
        end
        if (rst) begin
            grant     = '0;
            grant_any = 1'b0;
        end
    end

    assign req_ready = grant;
    assign sel_a     = req_a[int'(grant_id)*BITS +: BITS];
    assign ptr_next  = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
    assign head      = tag_p1[LATENCY-1];
    assign retire    = unit_out_valid && head.vld;

    // p0: issue register toward the shared unit, tag travels alongside
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= '0;
            busy          <= '0;
            unit_in_valid <= 1'b0;
            unit_a        <= '0;
            tag_p0        <= '0;
        end else begin
            if (grant_any) begin
                ptr    <= ptr_next;
                unit_a <= sel_a;
            end
            busy          <= (busy | grant) & ~(resp_valid & resp_ready);
            unit_in_valid <= grant_any;
            tag_p0.vld    <= grant_any;
            tag_p0.id     <= grant_id;
            tag_p0.ovf    <= ovf_of(sel_a);
        end
    end

    // p1: tag delay matching the unit latency
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) tag_p1[i] <= '0;
        end else begin
            tag_p1[0] <= tag_p0;
            for (int i = 1; i < LATENCY; i++) tag_p1[i] <= tag_p1[i-1];
        end
    end

    // p2: retire into per-requester result buffers; strobe/tag mismatch is sticky
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= '0;
            resp_c     <= '0;
            resp_ovf   <= '0;
            err        <= 1'b0;
        end else begin
            if (unit_out_valid != head.vld) err <= 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (retire && head.id == IDW'(i)) begin
                    resp_valid[i]          <= 1'b1;
                    resp_c[i*BITS +: BITS] <= unit_c;
                    resp_ovf[i]            <= head.ovf;
                end else if (resp_ready[i]) begin
                    resp_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule
